// File: rtl/operand_feeder.sv
// Operand feeder for an N x N systolic mesh: buffers north/west lanes, then streams them
// with a one-cycle-per-lane skew. Define OPERAND_FEEDER_REPLAY_EN to keep lane pointers across streams.
module operand_feeder #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int LW = (N > 1) ? $clog2(N) : 1,
    localparam int KW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  wr_en_i,
    input  logic                  wr_side_i,
    input  logic [LW-1:0]         wr_lane_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    input  logic [KW-1:0]         length_i,
    output logic [DATA_WIDTH-1:0] north_o [0:N-1],
    output logic [DATA_WIDTH-1:0] west_o  [0:N-1],
    output logic                  inputs_valid_o,
    output logic                  last_element_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int TW = $clog2(DEPTH + N + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef OPERAND_FEEDER_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           t_q, t_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    error_q;
    logic                    start_ok, start_bad;

    // Lanes 0..N-1 are the north bank, lanes N..2N-1 the west bank
    logic [DATA_WIDTH-1:0]   mem   [0:2*N-1][0:DEPTH-1];
    logic [KW-1:0]           ptr_q [0:2*N-1];

    logic                    lane_ok, wr_ok, wr_err;
    logic [LW-1:0]           lane_sel;
    int                      wl;
    logic [KW-1:0]           ptr_cur;

    logic [DATA_WIDTH-1:0]   north_d [0:N-1];
    logic [DATA_WIDTH-1:0]   west_d  [0:N-1];
    logic                    valid_d, last_d, done_d;

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        k_d       = k_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i != '0 && int'(length_i) <= DEPTH) begin
                        start_ok = 1'b1;
                        state_d  = STREAM;
                        t_d      = '0;
                        k_d      = length_i;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (int'(t_q) == int'(k_q) + N - 2) state_d = DONE;
                else                                t_d     = t_q + TW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_ok  = int'(wr_lane_i) < N;
        lane_sel = lane_ok ? wr_lane_i : '0;
        wl       = int'(wr_side_i) * N + int'(lane_sel);
        ptr_cur  = ptr_q[wl];
        wr_ok    = wr_en_i && lane_ok && state_q == IDLE && int'(ptr_cur) != DEPTH;
        wr_err   = wr_en_i && (state_q != IDLE || (lane_ok && int'(ptr_cur) == DEPTH));
    end

    // Outputs are computed from the next cycle index so the registered values line up with t
    always_comb begin
        int idx;
        idx     = 0;
        valid_d = (state_d == STREAM) && (t_d < TW'(k_d));
        last_d  = (state_d == STREAM) && (int'(t_d) == int'(k_d) + N - 2);
        done_d  = (state_d == DONE);
        for (int i = 0; i < N; i++) begin
            north_d[i] = '0;
            west_d[i]  = '0;
            idx = int'(t_d) - i;
            if (state_d == STREAM && idx >= 0 && idx < int'(k_d)) begin
                north_d[i] = mem[i][AW'(idx)];
                west_d[i]  = mem[N+i][AW'(idx)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            k_q     <= '0;
            error_q <= 1'b0;
            for (int j = 0; j < 2*N; j++) ptr_q[j] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            error_q <= (error_q & ~start_ok) | wr_err | start_bad;
            if (!REPLAY && state_q == DONE) begin
                for (int j = 0; j < 2*N; j++) ptr_q[j] <= '0;
            end else if (wr_ok) begin
                ptr_q[wl] <= ptr_cur + KW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wl][AW'(ptr_cur)] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inputs_valid_o <= 1'b0;
            last_element_o <= 1'b0;
            done_o         <= 1'b0;
            for (int i = 0; i < N; i++) begin
                north_o[i] <= '0;
                west_o[i]  <= '0;
            end
        end else begin
            inputs_valid_o <= valid_d;
            last_element_o <= last_d;
            done_o         <= done_d;
            for (int i = 0; i < N; i++) begin
                north_o[i] <= north_d[i];
                west_o[i]  <= west_d[i];
            end
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign error_o = error_q;

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter N, default 2, systolic array dimension; lane count per side.
REQ-002 Parameter DATA_WIDTH, default 32, element width.
REQ-003 Parameter DEPTH, default 8, maximum elements buffered per lane.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 wr_en_i  input  1  append wr_data_i to selected lane.
REQ-007 wr_side_i  input  1  0 = north lane bank, 1 = west lane bank.
REQ-008 wr_lane_i  input  $clog2(N) (min 1)  lane index within the bank.
REQ-009 wr_data_i  input  DATA_WIDTH  element to append.
REQ-010 start_i  input  1  begin streaming; length_i sampled the same cycle.
REQ-011 length_i  input  $clog2(DEPTH+1)  elements per lane K.
REQ-012 north_o  output  DATA_WIDTH x [0:N-1]  skewed column operands to mesh north_i.
REQ-013 west_o  output  DATA_WIDTH x [0:N-1]  skewed row operands to mesh west_i.
REQ-014 inputs_valid_o  output  1  valid for top-left PE.
REQ-015 last_element_o  output  1  one-cycle pulse when bottom west lane emits its final element.
REQ-016 busy_o  output  1  high in STREAM and DONE.
REQ-017 done_o  output  1  one-cycle pulse at end of stream.
REQ-018 error_o  output  1  sticky: overflow write, write while busy, or illegal start.

Function
REQ-019 Storage SHALL be 2N lanes of DEPTH entries, each with its own write pointer, starting at 0.
REQ-020 A write in IDLE SHALL store at the lane's pointer and increment it; pointer == DEPTH SHALL drop the write and set error_o.
REQ-021 A write while busy_o SHALL be dropped and set error_o.
REQ-022 FSM states SHALL be IDLE, STREAM, DONE; start_i outside IDLE SHALL be ignored without error.
REQ-023 start_i in IDLE with 1 <= K <= DEPTH SHALL move to STREAM and clear cycle counter t to 0; K = 0 or K > DEPTH SHALL set error_o and stay IDLE.
REQ-024 In STREAM at cycle t, lane i (both banks) SHALL output element t-i when 0 <= t-i < K, otherwise 0; all outputs registered.
REQ-025 inputs_valid_o SHALL be high for t = 0 .. K-1 only.
REQ-026 last_element_o SHALL pulse at t = K+N-2, together with the final west lane N-1 element.
REQ-027 STREAM SHALL last K+N-1 cycles (t = 0 .. K+N-2), then DONE for exactly one cycle with done_o = 1, then IDLE.
REQ-028 In DONE all write pointers SHALL clear to 0 (feature off, REQ-034) and data outputs SHALL be 0.
REQ-029 Lanes written with fewer than K elements SHALL stream stale storage contents without error.
REQ-030 error_o SHALL clear only on reset or on an accepted start_i.
REQ-031 Streaming latency: first element (lane 0) SHALL appear the cycle after start_i is sampled.

Reset
REQ-032 Reset assertion SHALL at once force IDLE, clear pointers, t, error_o, and drive every output to 0, including mid-stream; no pulse SHALL be emitted after reset.
REQ-033 Storage contents SHALL NOT require reset.

Configuration
REQ-034 Macro OPERAND_FEEDER_REPLAY_EN: when defined, pointers SHALL be kept in DONE, so a later start_i replays the same data and writes append; when undefined, pointers clear in DONE per REQ-028.

Verification
REQ-035 N=2, write north0={1,2}, north1={3,4}, west0={5,6}, west1={7,8}, start K=2 -> t0 N=(1,0) W=(5,0); t1 N=(2,3) W=(6,7); t2 N=(0,4) W=(0,8) with last_element_o; valid at t0-t1; done_o at t3.
REQ-036 Stream of K=1 -> STREAM 2 cycles, last_element_o at t=1, done_o one cycle later.
REQ-037 Ninth write to one lane with DEPTH=8 -> dropped, error_o=1; next legal start -> error_o=0.
REQ-038 start_i with K=0, then K=9 (DEPTH=8) -> error_o=1, busy_o stays 0.
REQ-039 rstn_i low at t=1 -> all outputs 0 immediately, no done_o or last_element_o afterwards.
REQ-040 With OPERAND_FEEDER_REPLAY_EN, two starts with K=2 and no rewrites -> identical output sequences; without it the second stream outputs stale data and pointers read 0.
